// File: rtl/pll_cfg_pkg.sv
// +----------------------------------------------------------------------+
// | pll_cfg_pkg : register map, C-word field layout and counter struct   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pll_cfg_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C      = 6'd5;
    localparam logic [5:0] ADDR_K      = 6'd7;

    localparam int C_CNT_W   = 18;
    localparam int C_IDX_LSB = 18;
    localparam int C_IDX_W   = 5;

    typedef struct packed {
        logic       odd;
        logic       bypass;
        logic [7:0] hi;
        logic [7:0] lo;
    } pll_cnt_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } cfg_state_t;

    function automatic pll_cnt_t to_cnt(input logic [31:0] word);
        return pll_cnt_t'(word[C_CNT_W-1:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_cfg_timer.sv
// +----------------------------------------------------------------------+
// | pll_cfg_timer : loadable down-counter that parks at zero (done)      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pll_cfg_timer #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK_50M,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pll_cfg_responder.sv
// +----------------------------------------------------------------------+
// | pll_cfg_responder : Avalon-MM PLL reconfig responder, shadow/apply   |
// | Optional shadow readback: define PLL_CFG_READBACK_EN.   Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module pll_cfg_responder
    import pll_cfg_pkg::*;
#(
    parameter int NUM_C         = 3,
    parameter int RECONF_CYCLES = 64,
    parameter int LOCK_CYCLES   = 256
) (
    input  logic                 CLK_50M,
    input  logic                 RESET,
    input  logic                 mgmt_write,
    input  logic                 mgmt_read,
    input  logic [5:0]           mgmt_address,
    input  logic [31:0]          mgmt_writedata,
    output logic [31:0]          mgmt_readdata,
    output logic                 mgmt_waitrequest,
    output logic [17:0]          n_cnt,
    output logic [17:0]          m_cnt,
    output logic [NUM_C*18-1:0]  c_cnt,
    output logic [31:0]          k_frac,
    output logic                 apply,
    output logic                 locked
);

    localparam int BUSY_W = $clog2(RECONF_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    cfg_state_t  state_q, state_d;
    logic        mode_q, mode_d;
    pll_cnt_t    n_sh_q, n_sh_d, m_sh_q, m_sh_d;
    pll_cnt_t    n_q, n_d, m_q, m_d;
    pll_cnt_t    c_sh_q [NUM_C];
    pll_cnt_t    c_sh_d [NUM_C];
    pll_cnt_t    c_q    [NUM_C];
    pll_cnt_t    c_d    [NUM_C];
    logic [31:0] k_sh_q, k_sh_d, k_q, k_d;
    logic [31:0] readdata_q, readdata_d;

    logic               wr_acc, rd_acc, start, apply_w;
    logic               busy_done, lock_done;
    logic [C_IDX_W-1:0] c_idx_w;

`ifdef PLL_CFG_READBACK_EN
    logic [C_IDX_W-1:0] c_idx_q, c_idx_d;
    pll_cnt_t           rb_c;
`endif

    // Writes only land in IDLE: waitrequest mode stalls them, polling mode drops them.
    always_comb begin
        c_idx_w          = mgmt_writedata[C_IDX_LSB +: C_IDX_W];
        mgmt_waitrequest = !RESET && !mode_q && (state_q == ST_BUSY)
                           && (mgmt_write || mgmt_read);
        wr_acc           = mgmt_write && (state_q == ST_IDLE);
        rd_acc           = mgmt_read && !mgmt_write && !mgmt_waitrequest;
        start            = wr_acc && (mgmt_address == ADDR_START);
        apply_w          = !RESET && (state_q == ST_BUSY) && busy_done;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_sh_d  = n_sh_q;
        m_sh_d  = m_sh_q;
        c_sh_d  = c_sh_q;
        k_sh_d  = k_sh_q;
        n_d     = n_q;
        m_d     = m_q;
        c_d     = c_q;
        k_d     = k_q;
`ifdef PLL_CFG_READBACK_EN
        c_idx_d = c_idx_q;
`endif

        case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (busy_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (apply_w) begin
            n_d = n_sh_q;
            m_d = m_sh_q;
            c_d = c_sh_q;
            k_d = k_sh_q;
        end

        if (wr_acc) begin
            case (mgmt_address)
                ADDR_MODE: mode_d = mgmt_writedata[0];
                ADDR_N:    n_sh_d = to_cnt(mgmt_writedata);
                ADDR_M:    m_sh_d = to_cnt(mgmt_writedata);
                ADDR_C: begin
`ifdef PLL_CFG_READBACK_EN
                    c_idx_d = c_idx_w;
`endif
                    for (int i = 0; i < NUM_C; i++) begin
                        if (int'(c_idx_w) == i) c_sh_d[i] = to_cnt(mgmt_writedata);
                    end
                end
                ADDR_K:    k_sh_d = mgmt_writedata;
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata_d = '0;
`ifdef PLL_CFG_READBACK_EN
        rb_c = '0;
        for (int i = 0; i < NUM_C; i++) begin
            if (int'(c_idx_q) == i) rb_c = c_sh_q[i];
        end
`endif
        if (rd_acc) begin
            case (mgmt_address)
                ADDR_STATUS: readdata_d = {31'b0, (state_q == ST_IDLE)};
`ifdef PLL_CFG_READBACK_EN
                ADDR_MODE:   readdata_d = {31'b0, mode_q};
                ADDR_N:      readdata_d = {14'b0, n_sh_q};
                ADDR_M:      readdata_d = {14'b0, m_sh_q};
                ADDR_C:      readdata_d = {9'b0, c_idx_q, rb_c};
                ADDR_K:      readdata_d = k_sh_q;
`endif
                default:     readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            n_sh_q     <= '0;
            m_sh_q     <= '0;
            k_sh_q     <= '0;
            n_q        <= '0;
            m_q        <= '0;
            k_q        <= '0;
            readdata_q <= '0;
            for (int i = 0; i < NUM_C; i++) begin
                c_sh_q[i] <= '0;
                c_q[i]    <= '0;
            end
`ifdef PLL_CFG_READBACK_EN
            c_idx_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_sh_q     <= n_sh_d;
            m_sh_q     <= m_sh_d;
            k_sh_q     <= k_sh_d;
            n_q        <= n_d;
            m_q        <= m_d;
            k_q        <= k_d;
            readdata_q <= readdata_d;
            c_sh_q     <= c_sh_d;
            c_q        <= c_d;
`ifdef PLL_CFG_READBACK_EN
            c_idx_q    <= c_idx_d;
`endif
        end
    end

    pll_cfg_timer #(
        .WIDTH   (BUSY_W),
        .RST_VAL (BUSY_W'(0))
    ) u_busy_timer (
        .CLK_50M  (CLK_50M),
        .RESET    (RESET),
        .load     (start),
        .load_val (BUSY_W'(RECONF_CYCLES - 1)),
        .done     (busy_done)
    );

    // Lock timer starts armed out of reset so lock is first gained LOCK_CYCLES after release.
    pll_cfg_timer #(
        .WIDTH   (LOCK_W),
        .RST_VAL (LOCK_W'(LOCK_CYCLES))
    ) u_lock_timer (
        .CLK_50M  (CLK_50M),
        .RESET    (RESET),
        .load     (apply_w),
        .load_val (LOCK_W'(LOCK_CYCLES)),
        .done     (lock_done)
    );

    generate
        for (genvar gi = 0; gi < NUM_C; gi++) begin : g_c_out
            assign c_cnt[gi*18 +: 18] = c_q[gi];
        end
    endgenerate

    assign n_cnt         = n_q;
    assign m_cnt         = m_q;
    assign k_frac        = k_q;
    assign apply         = apply_w;
    assign locked        = lock_done;
    assign mgmt_readdata = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_cfg_responder.sv
// +----------------------------------------------------------------------+
// | tb_pll_cfg_responder : directed + random bus traffic vs. ref model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pll_cfg_responder;

    localparam int NUM_C  = 3;
    localparam int RECONF = 64;
    localparam int LOCK   = 256;

    logic                CLK_50M = 1'b0;
    logic                RESET;
    logic                wr, rd;
    logic [5:0]          addr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                waitreq;
    logic [17:0]         n_cnt, m_cnt;
    logic [NUM_C*18-1:0] c_cnt;
    logic [31:0]         k_frac;
    logic                apply, locked;

    pll_cfg_responder #(
        .NUM_C         (NUM_C),
        .RECONF_CYCLES (RECONF),
        .LOCK_CYCLES   (LOCK)
    ) dut (
        .CLK_50M          (CLK_50M),
        .RESET            (RESET),
        .mgmt_write       (wr),
        .mgmt_read        (rd),
        .mgmt_address     (addr),
        .mgmt_writedata   (wdata),
        .mgmt_readdata    (rdata),
        .mgmt_waitrequest (waitreq),
        .n_cnt            (n_cnt),
        .m_cnt            (m_cnt),
        .c_cnt            (c_cnt),
        .k_frac           (k_frac),
        .apply            (apply),
        .locked           (locked)
    );

    always #10 CLK_50M = ~CLK_50M;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: busy_rem = BUSY cycles still to run (0 = idle), lock_rem = cycles to lock.
    int          busy_rem, lock_rem;
    bit          m_mode;
    logic [17:0] sh_n, sh_m, act_n, act_m;
    logic [17:0] sh_c [NUM_C];
    logic [17:0] act_c [NUM_C];
    logic [31:0] sh_k, act_k;
    logic [4:0]  m_cidx;
    bit          rd_pending, last_wait;
    logic [31:0] exp_rdata;

    task automatic model_reset();
        busy_rem = 0; lock_rem = LOCK; m_mode = 0; m_cidx = 0;
        sh_n = 0; sh_m = 0; act_n = 0; act_m = 0; sh_k = 0; act_k = 0;
        for (int i = 0; i < NUM_C; i++) begin sh_c[i] = 0; act_c[i] = 0; end
        rd_pending = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        logic [31:0] v;
        v = 0;
        if (a == 6'd1) v = (busy_rem == 0) ? 32'd1 : 32'd0;
`ifdef PLL_CFG_READBACK_EN
        case (a)
            6'd0: v = {31'b0, m_mode};
            6'd3: v = {14'b0, sh_n};
            6'd4: v = {14'b0, sh_m};
            6'd5: v = {9'b0, m_cidx, (int'(m_cidx) < NUM_C) ? sh_c[m_cidx] : 18'd0};
            6'd7: v = sh_k;
            default: ;
        endcase
`endif
        return v;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d);
        case (a)
            6'd0: m_mode = d[0];
            6'd2: busy_rem = RECONF;
            6'd3: sh_n = d[17:0];
            6'd4: sh_m = d[17:0];
            6'd5: begin
                m_cidx = d[22:18];
                if (int'(d[22:18]) < NUM_C) sh_c[d[22:18]] = d[17:0];
            end
            6'd7: sh_k = d;
            default: ;
        endcase
    endtask

    task automatic step();
        bit e_wait, e_apply, acc;
        int pre_busy;
        logic [NUM_C*18-1:0] pk;
        @(negedge CLK_50M);
        e_wait  = !RESET && !m_mode && busy_rem > 0 && (wr || rd);
        e_apply = !RESET && busy_rem == 1;
        last_wait = e_wait;
        for (int i = 0; i < NUM_C; i++) pk[i*18 +: 18] = act_c[i];
        check("waitrequest", 64'(waitreq), 64'(e_wait));
        check("apply",       64'(apply),   64'(e_apply));
        check("locked",      64'(locked),  64'(lock_rem == 0));
        check("n_cnt",       64'(n_cnt),   64'(act_n));
        check("m_cnt",       64'(m_cnt),   64'(act_m));
        check("c_cnt",       64'(c_cnt),   64'(pk));
        check("k_frac",      64'(k_frac),  64'(act_k));
        if (rd_pending) check("readdata", 64'(rdata), 64'(exp_rdata));
        if (RESET) begin
            model_reset();
        end else begin
            acc        = (wr || rd) && !e_wait;
            rd_pending = rd && !wr && acc;
            if (rd_pending) exp_rdata = model_read(addr);
            pre_busy = busy_rem;
            if (e_apply) begin
                act_n = sh_n; act_m = sh_m; act_k = sh_k;
                for (int i = 0; i < NUM_C; i++) act_c[i] = sh_c[i];
                lock_rem = LOCK;
                busy_rem = 0;
            end else begin
                if (busy_rem > 0) busy_rem--;
                if (lock_rem > 0) lock_rem--;
            end
            if (wr && acc && pre_busy == 0) model_write(addr, wdata);
        end
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Holds the transfer until accepted, as an Avalon master would.
    task automatic xfer(input bit w, input bit r, input logic [5:0] a, input logic [31:0] d);
        int n;
        wr = w; rd = r; addr = a; wdata = d;
        n = 0;
        do begin
            step();
            n++;
        end while (last_wait && n < 200);
        if (last_wait) check("xfer_timeout", 64'(1), 64'(0));
        wr = 0; rd = 0;
    endtask

    task automatic pulse_reset();
        RESET = 1;
        step();
        RESET = 0;
    endtask

    initial begin
        RESET = 1; wr = 0; rd = 0; addr = 0; wdata = 0;
        model_reset();
        @(posedge CLK_50M);
        #1;
        step();
        RESET = 0;
        idle(LOCK + 4);

        xfer(1, 0, 6'd0, 32'd0);
        xfer(1, 0, 6'd5, 32'h80909);
        xfer(1, 0, 6'd7, 32'd1503512573);
        xfer(1, 0, 6'd2, 32'd0);
        xfer(1, 0, 6'd3, 32'h00123);
        idle(LOCK + 4);

        xfer(1, 0, 6'd5, 32'h1C0808);
        xfer(1, 0, 6'd2, 32'd0);
        idle(RECONF + 4);

        xfer(1, 0, 6'd0, 32'd1);
        xfer(1, 0, 6'd2, 32'd0);
        xfer(1, 0, 6'd4, 32'h00505);
        xfer(0, 1, 6'd1, 32'd0);
        idle(RECONF);
        xfer(0, 1, 6'd1, 32'd0);
        idle(2);

        xfer(1, 0, 6'd2, 32'd0);
        idle(10);
        pulse_reset();
        idle(3);

        xfer(1, 0, 6'd3, 32'h00302);
        xfer(0, 1, 6'd3, 32'd0);
        xfer(1, 0, 6'd5, 32'h4ABCD);
        xfer(0, 1, 6'd5, 32'd0);
        xfer(1, 1, 6'd1, 32'd0);
        idle(2);

        for (int t = 0; t < 150; t++) begin
            logic [5:0]  a;
            logic [31:0] d;
            bit          w, r;
            a = 6'($urandom_range(0, 8));
            if (a == 6'd2 && $urandom_range(0, 3) != 0) a = 6'd3;
            d = $urandom;
            w = ($urandom_range(0, 2) != 0);
            r = !w || ($urandom_range(0, 7) == 0);
            xfer(w, r, a, d);
            idle($urandom_range(0, 3));
        end
        idle(RECONF + LOCK + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
